// File: rtl/mutex_monitor.sv
// N-channel mutual-exclusion checker: flags overlap, absence (EXACT mode) and
// over-long single-channel hold, with sticky flag, saturating count and first-vector capture.
module mutex_monitor #(
    parameter int N        = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_HOLD = 8,
    parameter bit EXACT    = 1'b0,
    parameter bit ASSERT_ON = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     req,
    output logic             viol,
    output logic [1:0]       viol_code,
    output logic             viol_sticky,
    output logic [CNT_W-1:0] viol_count,
    output logic [N-1:0]     first_vec
);

    // state   | meaning
    // IDLE    | en low, samples ignored, hold counter cleared
    // MONITOR | checking samples, no violation since clr/rst
    // LATCHED | checking samples, first violation captured
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        LATCHED = 2'd2
    } state_t;

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 2);
    localparam logic [HW-1:0]    HOLD_LIM = HW'(MAX_HOLD + 1);
    localparam logic [HW-1:0]    HOLD_ONE = HW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_OVERLAP = 2'b01;
    localparam logic [1:0] CODE_ABSENCE = 2'b10;
    localparam logic [1:0] CODE_HOLD    = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HW-1:0]    r_hold_cnt;
    logic [N-1:0]     r_prev;
    logic             r_viol;
    logic [1:0]       r_code;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;
    logic [N-1:0]     r_first_vec;

    logic             w_overlap;
    logic             w_absent;
    logic             w_onehot;
    logic [HW-1:0]    w_hold_nxt;
    logic             w_hold_hit;

    logic             w_viol_d;
    logic [1:0]       w_code_d;
    logic             w_sticky_d;
    logic [CNT_W-1:0] w_count_d;
    logic [N-1:0]     w_first_vec_d;
    logic [HW-1:0]    w_hold_d;
    logic [N-1:0]     w_prev_d;

    assign w_overlap = ($countones(req) > 1);
    assign w_onehot  = ($countones(req) == 1);
    assign w_absent  = EXACT && (req == '0);

    // Hold counter saturates at the limit so the hold violation fires only on arrival.
    always_comb begin
        w_hold_nxt = '0;
        if (w_onehot) begin
            if ((req == r_prev) && (r_hold_cnt != '0))
                w_hold_nxt = (r_hold_cnt == HOLD_LIM) ? HOLD_LIM : r_hold_cnt + HOLD_ONE;
            else
                w_hold_nxt = HOLD_ONE;
        end
    end

    assign w_hold_hit = (MAX_HOLD != 0) && (w_hold_nxt == HOLD_LIM) && (r_hold_cnt != HOLD_LIM);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = MONITOR;
                MONITOR: if (w_viol_d) w_state_nxt = LATCHED;
                LATCHED: if (clr) w_state_nxt = MONITOR;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_viol_d      = 1'b0;
        w_code_d      = CODE_NONE;
        w_sticky_d    = r_sticky;
        w_count_d     = r_count;
        w_first_vec_d = r_first_vec;
        w_hold_d      = r_hold_cnt;
        w_prev_d      = r_prev;
        if (clr) begin
            w_sticky_d    = 1'b0;
            w_count_d     = '0;
            w_first_vec_d = '0;
            w_hold_d      = '0;
            w_prev_d      = '0;
        end else if (!en) begin
            w_hold_d = '0;
        end else begin
            w_prev_d = req;
            w_hold_d = w_hold_nxt;
            if (w_overlap) begin
                w_viol_d = 1'b1;
                w_code_d = CODE_OVERLAP;
            end else if (w_absent) begin
                w_viol_d = 1'b1;
                w_code_d = CODE_ABSENCE;
            end else if (w_hold_hit) begin
                w_viol_d = 1'b1;
                w_code_d = CODE_HOLD;
            end
            if (w_viol_d) begin
                if (r_count != '1) w_count_d = r_count + CNT_ONE;
                if (!r_sticky) begin
                    w_sticky_d    = 1'b1;
                    w_first_vec_d = req;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_viol      <= 1'b0;
            r_code      <= CODE_NONE;
            r_sticky    <= 1'b0;
            r_count     <= '0;
            r_first_vec <= '0;
            r_hold_cnt  <= '0;
            r_prev      <= '0;
        end else begin
            r_viol      <= w_viol_d;
            r_code      <= w_code_d;
            r_sticky    <= w_sticky_d;
            r_count     <= w_count_d;
            r_first_vec <= w_first_vec_d;
            r_hold_cnt  <= w_hold_d;
            r_prev      <= w_prev_d;
        end
    end

    assign viol        = r_viol;
    assign viol_code   = r_code;
    assign viol_sticky = r_sticky;
    assign viol_count  = r_count;
    assign first_vec   = r_first_vec;

`ifndef SYNTHESIS
    generate
        if (ASSERT_ON) begin : g_assert
            a_no_overlap: assert property (@(posedge clk) disable iff (rst || !en)
                ($countones(req) <= 1))
                else $error("mutex_monitor: overlapping req %b", req);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mutex_monitor.sv
// Directed bench for mutex_monitor: one instance at-most-one-hot, one exactly-one-hot.
module tb_mutex_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] req;

    logic       viol, viol_x;
    logic [1:0] code, code_x;
    logic       sticky, sticky_x;
    logic [3:0] count, count_x;
    logic [3:0] fvec, fvec_x;

    int errors = 0;
    int checks = 0;

    mutex_monitor #(.N(4), .CNT_W(4), .MAX_HOLD(3), .EXACT(1'b0), .ASSERT_ON(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
        .viol(viol), .viol_code(code), .viol_sticky(sticky),
        .viol_count(count), .first_vec(fvec)
    );

    mutex_monitor #(.N(4), .CNT_W(4), .MAX_HOLD(3), .EXACT(1'b1), .ASSERT_ON(1'b0)) dut_x (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
        .viol(viol_x), .viol_code(code_x), .viol_sticky(sticky_x),
        .viol_count(count_x), .first_vec(fvec_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (viol !== 1'b0)     begin errors++; $display("FAIL reset_viol got=%b exp=0", viol); end
        checks++; if (code !== 2'b00)    begin errors++; $display("FAIL reset_code got=%b exp=00", code); end
        checks++; if (sticky !== 1'b0)   begin errors++; $display("FAIL reset_sticky got=%b exp=0", sticky); end
        checks++; if (count !== 4'd0)    begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (fvec !== 4'b0000)  begin errors++; $display("FAIL reset_fvec got=%b exp=0000", fvec); end
    endtask

    task automatic test_onehot();
        logic [3:0] vecs [3];
        vecs[0] = 4'b0001; vecs[1] = 4'b0010; vecs[2] = 4'b0100;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = vecs[i];
            tick();
            checks++; if (viol !== 1'b0) begin errors++; $display("FAIL onehot_viol[%0d] got=%b exp=0", i, viol); end
        end
        req = 4'b0000;
        tick();
        checks++; if (viol !== 1'b0)   begin errors++; $display("FAIL onehot_zero_viol got=%b exp=0", viol); end
        checks++; if (count !== 4'd0)  begin errors++; $display("FAIL onehot_count got=%0d exp=0", count); end
        checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL onehot_sticky got=%b exp=0", sticky); end
    endtask

    task automatic test_overlap();
        do_reset();
        en = 1'b1;
        req = 4'b0011;
        tick();
        checks++; if (viol !== 1'b1)    begin errors++; $display("FAIL ovl_viol got=%b exp=1", viol); end
        checks++; if (code !== 2'b01)   begin errors++; $display("FAIL ovl_code got=%b exp=01", code); end
        checks++; if (count !== 4'd1)   begin errors++; $display("FAIL ovl_count got=%0d exp=1", count); end
        checks++; if (sticky !== 1'b1)  begin errors++; $display("FAIL ovl_sticky got=%b exp=1", sticky); end
        checks++; if (fvec !== 4'b0011) begin errors++; $display("FAIL ovl_fvec got=%b exp=0011", fvec); end
        req = 4'b0001;
        tick();
        checks++; if (viol !== 1'b0)    begin errors++; $display("FAIL ovl_pulse_end got=%b exp=0", viol); end
        checks++; if (code !== 2'b00)   begin errors++; $display("FAIL ovl_code_none got=%b exp=00", code); end
        req = 4'b1100;
        tick();
        checks++; if (viol !== 1'b1)    begin errors++; $display("FAIL ovl2_viol got=%b exp=1", viol); end
        checks++; if (count !== 4'd2)   begin errors++; $display("FAIL ovl2_count got=%0d exp=2", count); end
        checks++; if (fvec !== 4'b0011) begin errors++; $display("FAIL ovl2_fvec got=%b exp=0011", fvec); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        en = 1'b1;
        req = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (viol !== (i == 4)) begin errors++; $display("FAIL hold_viol[%0d] got=%b exp=%b", i, viol, (i == 4)); end
            if (i == 4) begin
                checks++; if (code !== 2'b11) begin errors++; $display("FAIL hold_code got=%b exp=11", code); end
            end
        end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL hold_count got=%0d exp=1", count); end
        req = 4'b1000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (viol !== 1'b0) begin errors++; $display("FAIL hold_rearm[%0d] got=%b exp=0", i, viol); end
        end
        checks++; if (count !== 4'd1)   begin errors++; $display("FAIL hold_count2 got=%0d exp=1", count); end
        checks++; if (fvec !== 4'b0100) begin errors++; $display("FAIL hold_fvec got=%b exp=0100", fvec); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_exact();
        do_reset();
        en = 1'b1;
        req = 4'b0000;
        tick();
        checks++; if (viol_x !== 1'b1)  begin errors++; $display("FAIL exact_abs_viol got=%b exp=1", viol_x); end
        checks++; if (code_x !== 2'b10) begin errors++; $display("FAIL exact_abs_code got=%b exp=10", code_x); end
        checks++; if (viol !== 1'b0)    begin errors++; $display("FAIL amo_zero_viol got=%b exp=0", viol); end
        req = 4'b0110;
        tick();
        checks++; if (code_x !== 2'b01)  begin errors++; $display("FAIL exact_ovl_code got=%b exp=01", code_x); end
        checks++; if (count_x !== 4'd2)  begin errors++; $display("FAIL exact_count got=%0d exp=2", count_x); end
        checks++; if (fvec_x !== 4'b0000) begin errors++; $display("FAIL exact_fvec got=%b exp=0000", fvec_x); end
        req = 4'b0001;
        tick();
        checks++; if (viol_x !== 1'b0) begin errors++; $display("FAIL exact_onehot_viol got=%b exp=0", viol_x); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_cnt;
        do_reset();
        en = 1'b1;
        req = 4'b1111;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_cnt = (i < 15) ? 4'(i) : 4'd15;
            checks++; if (viol !== 1'b1)     begin errors++; $display("FAIL sat_viol[%0d] got=%b exp=1", i, viol); end
            checks++; if (count !== exp_cnt) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, count, exp_cnt); end
        end
        checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", sticky); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (viol !== 1'b0)    begin errors++; $display("FAIL clr_viol got=%b exp=0", viol); end
        checks++; if (count !== 4'd0)   begin errors++; $display("FAIL clr_count got=%0d exp=0", count); end
        checks++; if (sticky !== 1'b0)  begin errors++; $display("FAIL clr_sticky got=%b exp=0", sticky); end
        checks++; if (fvec !== 4'b0000) begin errors++; $display("FAIL clr_fvec got=%b exp=0000", fvec); end
        tick();
        checks++; if (viol !== 1'b1)    begin errors++; $display("FAIL clr_rearm_viol got=%b exp=1", viol); end
        checks++; if (fvec !== 4'b1111) begin errors++; $display("FAIL clr_rearm_fvec got=%b exp=1111", fvec); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_rst_en();
        do_reset();
        en = 1'b1;
        req = 4'b0011;
        tick();
        checks++; if (viol !== 1'b1) begin errors++; $display("FAIL pre_rst_viol got=%b exp=1", viol); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (viol !== 1'b0)    begin errors++; $display("FAIL mid_rst_viol got=%b exp=0", viol); end
        checks++; if (count !== 4'd0)   begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        checks++; if (sticky !== 1'b0)  begin errors++; $display("FAIL mid_rst_sticky got=%b exp=0", sticky); end
        checks++; if (fvec !== 4'b0000) begin errors++; $display("FAIL mid_rst_fvec got=%b exp=0000", fvec); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (viol !== 1'b0)  begin errors++; $display("FAIL en0_viol[%0d] got=%b exp=0", i, viol); end
            checks++; if (count !== 4'd0) begin errors++; $display("FAIL en0_count[%0d] got=%0d exp=0", i, count); end
        end
        en = 1'b1;
        tick();
        checks++; if (viol !== 1'b1)  begin errors++; $display("FAIL en1_viol got=%b exp=1", viol); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL en1_count got=%0d exp=1", count); end
        en = 1'b0;
        tick();
        checks++; if (viol !== 1'b0)    begin errors++; $display("FAIL en_drop_viol got=%b exp=0", viol); end
        checks++; if (count !== 4'd1)   begin errors++; $display("FAIL en_drop_count got=%0d exp=1", count); end
        checks++; if (sticky !== 1'b1)  begin errors++; $display("FAIL en_drop_sticky got=%b exp=1", sticky); end
        checks++; if (fvec !== 4'b0011) begin errors++; $display("FAIL en_drop_fvec got=%b exp=0011", fvec); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; req = 4'b0000;
        test_reset();
        test_onehot();
        test_overlap();
        test_hold();
        test_exact();
        test_saturate();
        test_rst_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
